// File: rtl/zigbee_cordic_arbiter.sv
// rtl/zigbee_cordic_arbiter.sv - round-robin sharing of one CORDIC phase datapath between IQ requesters
module zigbee_cordic_arbiter #(
  parameter int IQ_SIZE   = 5,
  parameter int W_SIZE    = 6,
  parameter int N_REQ     = 2,
  parameter int TAG_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*IQ_SIZE-1:0]     req_ibb,
  input  logic [N_REQ*IQ_SIZE-1:0]     req_qbb,
  output logic [N_REQ-1:0]             req_ready,
  output logic [IQ_SIZE-1:0]           cordic_ibb,
  output logic [IQ_SIZE-1:0]           cordic_qbb,
  output logic                         cordic_iValid,
  input  logic [W_SIZE-1:0]            cordic_wout,
  input  logic                         cordic_oValid,
  output logic [N_REQ-1:0]             rsp_valid,
  output logic [W_SIZE-1:0]            rsp_wout,
  output logic [$clog2(TAG_DEPTH):0]   inflight,
  output logic                         err_orphan
);

  localparam int TW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int AW = $clog2(TAG_DEPTH);
  localparam int CW = AW + 1;

  logic [TW-1:0]      last_grant;
  logic [TW-1:0]      gnt_idx;
  logic               gnt_found;
  logic               full;
  logic               push;
  logic               pop;
  logic               orphan;
  logic [IQ_SIZE-1:0] sel_i;
  logic [IQ_SIZE-1:0] sel_q;
  logic [TW-1:0]      tag_mem [TAG_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;

  // Round-robin search from the requester after the last grant; full ignores a same-cycle pop
  always_comb begin
    int k;
    k         = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      k = (int'(last_grant) + 1 + i) % N_REQ;
      if (!gnt_found && req_valid[k]) begin
        gnt_found = 1'b1;
        gnt_idx   = TW'(k);
      end
    end
    full      = (inflight == CW'(TAG_DEPTH));
    push      = gnt_found && !full && reset_n;
    req_ready = push ? (N_REQ'(1) << gnt_idx) : '0;
    pop       = cordic_oValid && (inflight != '0);
    orphan    = cordic_oValid && (inflight == '0);
    sel_i     = req_ibb[int'(gnt_idx)*IQ_SIZE +: IQ_SIZE];
    sel_q     = req_qbb[int'(gnt_idx)*IQ_SIZE +: IQ_SIZE];
  end

  // Issue stage: register the granted sample toward the CORDIC and remember the winner
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cordic_iValid <= 1'b0;
      cordic_ibb    <= '0;
      cordic_qbb    <= '0;
      last_grant    <= TW'(N_REQ - 1);
    end else begin
      cordic_iValid <= push;
      if (push) begin
        cordic_ibb <= sel_i;
        cordic_qbb <= sel_q;
        last_grant <= gnt_idx;
      end
    end
  end

  // Tag storage; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= gnt_idx;
    end
  end

  // Tag FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      inflight <= inflight + CW'(push) - CW'(pop);
    end
  end

  // Return stage: route each CORDIC result to the requester at the FIFO head
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rsp_valid  <= '0;
      rsp_wout   <= '0;
      err_orphan <= 1'b0;
    end else begin
      rsp_valid <= pop ? (N_REQ'(1) << tag_mem[rd_ptr]) : '0;
      if (pop)    rsp_wout   <= cordic_wout;
      if (orphan) err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_zigbee_cordic_arbiter.sv
// tb/tb_zigbee_cordic_arbiter.sv - scoreboard bench for zigbee_cordic_arbiter with a stub CORDIC
module tb_zigbee_cordic_arbiter;
  localparam int IQ = 5;
  localparam int W  = 6;
  localparam int N  = 2;
  localparam int D  = 8;
  localparam int LS = 3;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N*IQ-1:0]  req_ibb = '0;
  logic [N*IQ-1:0]  req_qbb = '0;
  logic [N-1:0]     req_ready;
  logic [IQ-1:0]    cordic_ibb, cordic_qbb;
  logic             cordic_iValid;
  logic [W-1:0]     cordic_wout = '0;
  logic             cordic_oValid = 1'b0;
  logic [N-1:0]     rsp_valid;
  logic [W-1:0]     rsp_wout;
  logic [$clog2(D):0] inflight;
  logic             err_orphan;

  zigbee_cordic_arbiter #(.IQ_SIZE(IQ), .W_SIZE(W), .N_REQ(N), .TAG_DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ibb(req_ibb), .req_qbb(req_qbb),
    .req_ready(req_ready), .cordic_ibb(cordic_ibb), .cordic_qbb(cordic_qbb),
    .cordic_iValid(cordic_iValid), .cordic_wout(cordic_wout), .cordic_oValid(cordic_oValid),
    .rsp_valid(rsp_valid), .rsp_wout(rsp_wout), .inflight(inflight), .err_orphan(err_orphan)
  );

  always #10 clk = ~clk;

  typedef struct { int k; logic [W-1:0] ph; } tag_t;
  typedef struct { int k; logic [W-1:0] w; int due; } rsp_t;
  typedef struct { logic [W-1:0] w; int due; } stub_t;

  tag_t  tags[$];
  rsp_t  expq[$];
  stub_t stubq[$];

  int checks = 0, errors = 0, cyc = 0, rsp_cnt = 0;
  int rr = 0, rel = 0;
  bit orphan_m = 0, iss_v = 0, stall = 0, force_ov = 0;
  logic [IQ-1:0] iss_i = '0, iss_q = '0;
  int dut_g[N];
  logic [N-1:0] last_rv = '0;
  logic [W-1:0] last_rw = '0, hold = '0;

  function automatic logic [W-1:0] phase_of(input logic [IQ-1:0] i, input logic [IQ-1:0] q);
    real a;
    int p;
    a = $atan2($itor($signed(q)), $itor($signed(i)));
    p = $rtoi($floor(a * 64.0 / (2.0 * 3.141592653589793) + 0.5));
    return W'(p);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((tags.size() != 0 || expq.size() != 0 || stubq.size() != 0) && n < 200) begin
      step();
      n++;
    end
    chk("drain_timeout", n < 200, 1);
    step();
  endtask

  task automatic rand_samples();
    req_ibb = N*IQ'($urandom);
    req_qbb = N*IQ'($urandom);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model plus stub CORDIC, evaluated mid-cycle once inputs have settled
  initial forever begin
    int gk, k;
    bit ov, full;
    logic [W-1:0] w;
    tag_t t;
    @(posedge clk);
    #3;
    if (!reset_n) begin
      chk("ready_in_reset", req_ready, 0);
      cordic_oValid = 1'b0;
      tags.delete();
      stubq.delete();
      rr = 0; orphan_m = 0; iss_v = 0; iss_i = '0; iss_q = '0;
    end else begin
      chk("cordic_iValid", cordic_iValid, iss_v);
      chk("cordic_ibb", cordic_ibb, iss_i);
      chk("cordic_qbb", cordic_qbb, iss_q);
      chk("inflight", inflight, tags.size());
      chk("err_orphan", err_orphan, orphan_m);
      for (int j = 0; j < N; j++) if (req_valid[j] && req_ready[j]) dut_g[j]++;
      if (cordic_iValid) stubq.push_back('{phase_of(cordic_ibb, cordic_qbb), cyc + LS});
      ov = 0;
      w = W'($urandom);
      if (force_ov) begin
        ov = 1;
      end else if (stubq.size() > 0 && stubq[0].due <= cyc && (!stall || rel > 0)) begin
        ov = 1;
        w = stubq[0].w;
        void'(stubq.pop_front());
        if (stall) rel--;
      end
      cordic_oValid = ov;
      cordic_wout = w;
      full = (tags.size() == D);
      gk = -1;
      if (!full) begin
        for (int i = 0; i < N; i++) begin
          k = (rr + i) % N;
          if (gk < 0 && req_valid[k]) gk = k;
        end
      end
      chk("req_ready", req_ready, (gk >= 0) ? (1 << gk) : 0);
      if (ov) begin
        if (tags.size() > 0) begin
          t = tags.pop_front();
          expq.push_back('{t.k, t.ph, cyc + 1});
        end else begin
          orphan_m = 1;
        end
      end
      if (gk >= 0) begin
        iss_i = req_ibb[gk*IQ +: IQ];
        iss_q = req_qbb[gk*IQ +: IQ];
        tags.push_back('{gk, phase_of(iss_i, iss_q)});
        rr = (gk + 1) % N;
        iss_v = 1;
      end else begin
        iss_v = 0;
      end
    end
  end

  // Monitor: pop the scoreboard whenever a response is due and compare
  initial forever begin
    rsp_t e;
    @(negedge clk);
    if (expq.size() > 0 && expq[0].due == cyc) begin
      e = expq.pop_front();
      chk("rsp_valid", rsp_valid, 1 << e.k);
      chk("rsp_wout", rsp_wout, e.w);
      hold = e.w;
      rsp_cnt++;
      last_rv = rsp_valid;
      last_rw = rsp_wout;
    end else begin
      chk("rsp_idle", rsp_valid, 0);
      chk("rsp_hold", rsp_wout, hold);
    end
    if (!reset_n) hold = '0;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int r0;
    repeat (3) step();
    reset_n = 1'b1;
    step();
    chk("rst_iValid", cordic_iValid, 0);
    chk("rst_ibb", cordic_ibb, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_wout", rsp_wout, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_orphan", err_orphan, 0);

    // single requester, phase 0
    req_ibb[0 +: IQ] = 5'd15; req_qbb[0 +: IQ] = 5'd0; req_valid = 2'b01;
    step();
    req_valid = '0;
    drain();
    chk("t1_rsp_valid", last_rv, 2'b01);
    chk("t1_rsp_wout", last_rw, 0);
    chk("t1_inflight", inflight, 0);

    // phase routing to requester 1, 90 degrees
    req_ibb[IQ +: IQ] = 5'd0; req_qbb[IQ +: IQ] = 5'd15; req_valid = 2'b10;
    step();
    req_valid = '0;
    drain();
    chk("t2_rsp_valid", last_rv, 2'b10);
    chk("t2_rsp_wout", last_rw, 16);

    // fairness
    for (int j = 0; j < N; j++) dut_g[j] = 0;
    r0 = rsp_cnt;
    req_valid = 2'b11;
    for (int c = 0; c < 10; c++) begin rand_samples(); step(); end
    req_valid = '0;
    drain();
    chk("fair_g0", dut_g[0], 5);
    chk("fair_g1", dut_g[1], 5);
    chk("fair_rsp", rsp_cnt - r0, 10);

    // backpressure
    for (int j = 0; j < N; j++) dut_g[j] = 0;
    stall = 1; rel = 0;
    req_valid = 2'b01;
    for (int c = 0; c < 12; c++) begin rand_samples(); step(); end
    chk("bp_grants", dut_g[0], 8);
    chk("bp_inflight", inflight, 8);
    chk("bp_ready", req_ready, 0);
    r0 = rsp_cnt;
    rel = 1;
    step();
    chk("bp_regrant", req_ready, 2'b01);
    step();
    req_valid = '0;
    chk("bp_grants2", dut_g[0], 9);
    repeat (3) step();
    chk("bp_one_rsp", rsp_cnt - r0, 1);
    stall = 0;
    drain();

    // randomized traffic with random stalls
    for (int c = 0; c < 300; c++) begin
      req_valid = N'($urandom);
      rand_samples();
      stall = ($urandom_range(0, 3) == 0);
      rel = 0;
      step();
    end
    req_valid = '0; stall = 0;
    drain();

    // orphan
    force_ov = 1;
    step();
    force_ov = 0;
    step();
    chk("orphan_set", err_orphan, 1);
    repeat (5) step();
    chk("orphan_sticky", err_orphan, 1);
    chk("orphan_inflight", inflight, 0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    chk("orphan_cleared", err_orphan, 0);

    // reset mid-operation
    stall = 1; rel = 0;
    req_valid = 2'b01;
    repeat (3) begin rand_samples(); step(); end
    req_valid = '0;
    step();
    chk("mid_inflight", inflight, 3);
    reset_n = 1'b0;
    req_valid = 2'b11;
    step();
    reset_n = 1'b1;
    req_valid = '0;
    stall = 0;
    step();
    chk("mid_iValid", cordic_iValid, 0);
    chk("mid_ibb", cordic_ibb, 0);
    chk("mid_qbb", cordic_qbb, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_rsp_wout", rsp_wout, 0);
    chk("mid_inflight0", inflight, 0);
    chk("mid_orphan", err_orphan, 0);
    repeat (10) step();
    rand_samples();
    req_valid = 2'b11;
    #1;
    chk("mid_first_grant", req_ready, 2'b01);
    step();
    req_valid = '0;
    drain();

    chk("end_expq_empty", expq.size(), 0);
    chk("end_tags_empty", tags.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
